// File: rtl/crg_seq_ctrl_if.sv
// Handshake/status bundle between the clock/reset sequencer and its user.
// master: drives lock, enable and select requests; slave: the sequencer.
interface crg_seq_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic                      mmcm_locked;
    logic [NUM_CH-1:0]         ch_en_req;
    logic [NUM_CH*SEL_W-1:0]   ch_sel_req;
    logic [NUM_CH-1:0]         ch_sel_upd;
    logic [NUM_CH-1:0]         ch_gce;
    logic [NUM_CH*SEL_W-1:0]   ch_sel;
    logic [NUM_CH-1:0]         ch_rst_n;
    logic [NUM_CH-1:0]         ch_busy;
    logic                      all_ready;

    modport master (
        output mmcm_locked, ch_en_req, ch_sel_req, ch_sel_upd,
        input  ch_gce, ch_sel, ch_rst_n, ch_busy, all_ready
    );

    modport slave (
        input  mmcm_locked, ch_en_req, ch_sel_req, ch_sel_upd,
        output ch_gce, ch_sel, ch_rst_n, ch_busy, all_ready
    );
endinterface

// File: rtl/crg_seq_ctrl.sv
// Clock/reset generator sequencer: lock qualify, staggered reset release,
// glitch-safe per-channel BUFGMUX switching. Ports: clk_src, rst_sys, bus.
module crg_seq_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int SEL_W    = 2,
    parameter int LOCK_DLY = 16,
    parameter int RST_DLY  = 8,
    parameter int SW_GAP   = 4
) (
    input  logic           clk_src,
    input  logic           rst_sys,
    crg_seq_ctrl_if.slave  bus
);
    localparam int MAXD = (LOCK_DLY > RST_DLY)
        ? ((LOCK_DLY > SW_GAP) ? LOCK_DLY : SW_GAP)
        : ((RST_DLY > SW_GAP) ? RST_DLY : SW_GAP);
    localparam int CW = $clog2(MAXD + 1);

    typedef enum logic [1:0] {
        G_WAIT_LOCK, G_RELEASE, G_RUN
    } gst_e;

    typedef enum logic [1:0] {
        C_RUN, C_GATE, C_SWITCH, C_RESET
    } cst_e;

    logic                    lk1_q, lk2_q;
    gst_e                    g_q, g_d;
    logic [CW-1:0]           gcnt_q, gcnt_d;
    logic [NUM_CH-1:0]       gce_q, gce_d;
    logic [NUM_CH*SEL_W-1:0] sel_q, sel_d;
    logic [NUM_CH-1:0]       rstn_q, rstn_d;
    logic [NUM_CH-1:0]       busy_q, busy_d;
    logic                    rdy_q, rdy_d;
    cst_e                    cst_q [NUM_CH];
    cst_e                    cst_d [NUM_CH];
    logic [CW-1:0]           ccnt_q [NUM_CH];
    logic [CW-1:0]           ccnt_d [NUM_CH];
    logic [SEL_W-1:0]        lat_q [NUM_CH];
    logic [SEL_W-1:0]        lat_d [NUM_CH];
    logic                    lose;

    // lk2_q is the synchronised lock (lock_s)
    assign lose = !lk2_q && (g_q != G_WAIT_LOCK);

    always_comb begin
        g_d    = g_q;
        gcnt_d = gcnt_q;
        gce_d  = gce_q;
        sel_d  = sel_q;
        rstn_d = rstn_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cst_d[i]  = cst_q[i];
            ccnt_d[i] = ccnt_q[i];
            lat_d[i]  = lat_q[i];
        end
        if (lose) begin
            // Select is kept so the mux stays on a known source
            g_d    = G_WAIT_LOCK;
            gcnt_d = '0;
            gce_d  = '0;
            rstn_d = '0;
            busy_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cst_d[i]  = C_RUN;
                ccnt_d[i] = '0;
            end
        end else begin
            unique case (g_q)
                G_WAIT_LOCK: begin
                    if (!lk2_q) begin
                        gcnt_d = '0;
                    end else if (gcnt_q == CW'(LOCK_DLY - 1)) begin
                        gcnt_d = '0;
                        g_d    = G_RELEASE;
                        rstn_d = NUM_CH'(1);
                        if (&rstn_d) g_d = G_RUN;
                    end else begin
                        gcnt_d = gcnt_q + CW'(1);
                    end
                end
                G_RELEASE: begin
                    // rstn is a thermometer code; shift in the next channel
                    if (gcnt_q == CW'(RST_DLY - 1)) begin
                        gcnt_d = '0;
                        rstn_d = (rstn_q << 1) | NUM_CH'(1);
                        if (&rstn_d) g_d = G_RUN;
                    end else begin
                        gcnt_d = gcnt_q + CW'(1);
                    end
                end
                G_RUN: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        unique case (cst_q[i])
                            C_RUN: begin
                                gce_d[i] = bus.ch_en_req[i] & rstn_q[i];
                                if (bus.ch_sel_upd[i] &&
                                    bus.ch_sel_req[i*SEL_W +: SEL_W]
                                    != sel_q[i*SEL_W +: SEL_W]) begin
                                    lat_d[i]  = bus.ch_sel_req[i*SEL_W +: SEL_W];
                                    busy_d[i] = 1'b1;
                                    gce_d[i]  = 1'b0;
                                    ccnt_d[i] = '0;
                                    cst_d[i]  = C_GATE;
                                end
                            end
                            C_GATE: begin
                                gce_d[i] = 1'b0;
                                if (ccnt_q[i] == CW'(SW_GAP - 1)) begin
                                    ccnt_d[i] = '0;
                                    sel_d[i*SEL_W +: SEL_W] = lat_q[i];
                                    cst_d[i]  = C_SWITCH;
                                end else begin
                                    ccnt_d[i] = ccnt_q[i] + CW'(1);
                                end
                            end
                            C_SWITCH: begin
                                if (ccnt_q[i] == CW'(SW_GAP - 1)) begin
                                    ccnt_d[i] = '0;
                                    rstn_d[i] = 1'b0;
                                    cst_d[i]  = C_RESET;
                                end else begin
                                    ccnt_d[i] = ccnt_q[i] + CW'(1);
                                end
                            end
                            C_RESET: begin
                                if (ccnt_q[i] == CW'(RST_DLY - 1)) begin
                                    ccnt_d[i] = '0;
                                    rstn_d[i] = 1'b1;
                                    busy_d[i] = 1'b0;
                                    cst_d[i]  = C_RUN;
                                end else begin
                                    ccnt_d[i] = ccnt_q[i] + CW'(1);
                                end
                            end
                        endcase
                    end
                end
                default: g_d = G_WAIT_LOCK;
            endcase
        end
        rdy_d = (g_d == G_RUN) && (&rstn_d);
    end

    always_ff @(posedge clk_src or posedge rst_sys) begin
        if (rst_sys) begin
            lk1_q  <= 1'b0;
            lk2_q  <= 1'b0;
            g_q    <= G_WAIT_LOCK;
            gcnt_q <= '0;
            gce_q  <= '0;
            sel_q  <= '0;
            rstn_q <= '0;
            busy_q <= '0;
            rdy_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cst_q[i]  <= C_RUN;
                ccnt_q[i] <= '0;
                lat_q[i]  <= '0;
            end
        end else begin
            lk1_q  <= bus.mmcm_locked;
            lk2_q  <= lk1_q;
            g_q    <= g_d;
            gcnt_q <= gcnt_d;
            gce_q  <= gce_d;
            sel_q  <= sel_d;
            rstn_q <= rstn_d;
            busy_q <= busy_d;
            rdy_q  <= rdy_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cst_q[i]  <= cst_d[i];
                ccnt_q[i] <= ccnt_d[i];
                lat_q[i]  <= lat_d[i];
            end
        end
    end

    assign bus.ch_gce    = gce_q;
    assign bus.ch_sel    = sel_q;
    assign bus.ch_rst_n  = rstn_q;
    assign bus.ch_busy   = busy_q;
    assign bus.all_ready = rdy_q;
endmodule

// File: tb/tb_crg_seq_ctrl.sv
// Bench for crg_seq_ctrl: timeline-based reference model,
// directed power-up/switch/lock-loss cases plus random traffic.
module tb_crg_seq_ctrl;
    localparam int NUM_CH   = 4;
    localparam int SEL_W    = 2;
    localparam int LOCK_DLY = 16;
    localparam int RST_DLY  = 8;
    localparam int SW_GAP   = 4;
    localparam int SWD      = 2 * SW_GAP + RST_DLY;
    localparam int RUN_E    = (NUM_CH - 1) * RST_DLY;

    logic clk_src = 1'b0;
    logic rst_sys = 1'b1;

    crg_seq_ctrl_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

    crg_seq_ctrl #(
        .NUM_CH(NUM_CH), .SEL_W(SEL_W), .LOCK_DLY(LOCK_DLY),
        .RST_DLY(RST_DLY), .SW_GAP(SW_GAP)
    ) dut (
        .clk_src(clk_src),
        .rst_sys(rst_sys),
        .bus(bus.slave)
    );

    always #5 clk_src = ~clk_src;

    int n_chk = 0;
    int n_err = 0;

    // reference model state: edge index, release time, switch start times
    int  cyc;
    bit  mode;
    int  rel_t;
    int  lcnt;
    bit  m1, m2;
    int  sw_t [NUM_CH];
    logic [SEL_W-1:0] msel [NUM_CH];
    logic [SEL_W-1:0] pend [NUM_CH];

    logic [NUM_CH-1:0]       e_gce, e_rstn, e_busy;
    logic [NUM_CH*SEL_W-1:0] e_sel;
    logic                    e_rdy;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_out();
        e_gce  = '0;
        e_rstn = '0;
        e_busy = '0;
        e_rdy  = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            e_sel[i*SEL_W +: SEL_W] = msel[i];
    endtask

    task automatic model_reset();
        mode = 0;
        lcnt = 0;
        m1   = 0;
        m2   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            sw_t[i] = -1;
            msel[i] = '0;
        end
        model_out();
    endtask

    task automatic model_edge();
        bit ls;
        bit run_b;
        int d;
        ls = m2;
        cyc++;
        run_b = mode && ((cyc - 1 - rel_t) >= RUN_E);
        m2 = m1;
        m1 = bus.mmcm_locked;
        if (!mode) begin
            if (ls) begin
                lcnt++;
                if (lcnt == LOCK_DLY) begin
                    mode  = 1;
                    rel_t = cyc;
                    lcnt  = 0;
                end
            end else begin
                lcnt = 0;
            end
        end else if (!ls) begin
            mode = 0;
            lcnt = 0;
            for (int i = 0; i < NUM_CH; i++) sw_t[i] = -1;
        end else if (run_b) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sw_t[i] >= 0 && cyc - sw_t[i] == SW_GAP)
                    msel[i] = pend[i];
                if (sw_t[i] >= 0 && cyc - sw_t[i] > SWD)
                    sw_t[i] = -1;
                if (sw_t[i] < 0 && bus.ch_sel_upd[i] &&
                    bus.ch_sel_req[i*SEL_W +: SEL_W] != msel[i]) begin
                    sw_t[i] = cyc;
                    pend[i] = bus.ch_sel_req[i*SEL_W +: SEL_W];
                end
            end
        end
        model_out();
        if (mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                d = cyc - sw_t[i];
                e_busy[i] = sw_t[i] >= 0 && d < SWD;
                e_rstn[i] = (cyc - rel_t) >= i * RST_DLY &&
                    !(sw_t[i] >= 0 && d >= 2 * SW_GAP && d < SWD);
                e_gce[i] = run_b && bus.ch_en_req[i] &&
                    !(sw_t[i] >= 0 && d <= SWD);
            end
            e_rdy = ((cyc - rel_t) >= RUN_E) && (&e_rstn);
        end
    endtask

    task automatic check_all();
        chk("gce",   32'(bus.ch_gce),    32'(e_gce));
        chk("sel",   32'(bus.ch_sel),    32'(e_sel));
        chk("rstn",  32'(bus.ch_rst_n),  32'(e_rstn));
        chk("busy",  32'(bus.ch_busy),   32'(e_busy));
        chk("ready", 32'(bus.all_ready), 32'(e_rdy));
    endtask

    // one clock: sample 1 ns after the edge, then park on the negedge
    task automatic step();
        @(posedge clk_src);
        #1;
        if (rst_sys) model_reset();
        else model_edge();
        check_all();
        @(negedge clk_src);
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_ready(string tag);
        int n;
        n = 0;
        while (!bus.all_ready && n < 300) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.all_ready), 32'd1);
    endtask

    task automatic strobe(int ch, logic [SEL_W-1:0] v);
        bus.ch_sel_req[ch*SEL_W +: SEL_W] = v;
        bus.ch_sel_upd[ch] = 1'b1;
        step();
        bus.ch_sel_upd = '0;
    endtask

    // asynchronous reset applied between clock edges
    task automatic async_rst();
        #2 rst_sys = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk_src);
        rst_sys = 1'b0;
    endtask

    initial begin
        int n;
        logic [SEL_W-1:0] s1;
        cyc = 0;
        bus.mmcm_locked = 1'b0;
        bus.ch_en_req   = '1;
        bus.ch_sel_req  = '0;
        bus.ch_sel_upd  = '0;
        model_reset();
        @(negedge clk_src);
        #1;
        check_all();
        steps(2);
        chk("rst_rstn", 32'(bus.ch_rst_n), 32'd0);

        // power-up: ready after 2 sync + 16 lock + 3*8 release edges
        @(negedge clk_src);
        rst_sys = 1'b0;
        bus.mmcm_locked = 1'b1;
        n = 0;
        while (!bus.all_ready && n < 100) begin
            step();
            n++;
        end
        chk("pu_lat", 32'(n), 32'd42);
        step();
        chk("pu_gce", 32'(bus.ch_gce), 32'hf);

        // switch ch1 to 2, late strobe dropped, equal strobe ignored
        strobe(1, 2'd2);
        chk("sw_busy", 32'(bus.ch_busy), 32'h2);
        steps(3);
        strobe(1, 2'd3);
        steps(20);
        chk("sw_sel", 32'(bus.ch_sel[3:2]), 32'd2);
        chk("sw_gce", 32'(bus.ch_gce), 32'hf);
        strobe(1, 2'd2);
        chk("eq_busy", 32'(bus.ch_busy), 32'h0);
        steps(3);

        // lock loss while ch2 is in its switch phase
        strobe(2, 2'd1);
        steps(2);
        bus.mmcm_locked = 1'b0;
        steps(4);
        chk("ll_rstn", 32'(bus.ch_rst_n), 32'h0);
        chk("ll_sel2", 32'(bus.ch_sel[5:4]), 32'd1);
        bus.mmcm_locked = 1'b1;
        // lock glitch during the lock count
        steps(12);
        bus.mmcm_locked = 1'b0;
        step();
        bus.mmcm_locked = 1'b1;
        wait_ready("relock_rdy");

        // async reset during release
        bus.mmcm_locked = 1'b0;
        steps(3);
        bus.mmcm_locked = 1'b1;
        steps(30);
        async_rst();
        chk("ar_rstn", 32'(bus.ch_rst_n), 32'h0);
        wait_ready("ar_rdy");

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                s1 = SEL_W'($urandom);
                bus.ch_sel_req[i*SEL_W +: SEL_W] = s1;
                bus.ch_sel_upd[i] = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 63) == 0)
                    bus.ch_en_req[i] = ~bus.ch_en_req[i];
            end
            if (bus.mmcm_locked && $urandom_range(0, 399) == 0)
                bus.mmcm_locked = 1'b0;
            else if (!bus.mmcm_locked && $urandom_range(0, 3) == 0)
                bus.mmcm_locked = 1'b1;
            if ($urandom_range(0, 1499) == 0) async_rst();
            else step();
            bus.ch_sel_upd = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_err);
        $finish;
    end
endmodule
